// File: rtl/invaders_video_pkg.sv
// Raster geometry, framebuffer placement and interrupt vectors for the
// invaders video fetch block.
package invaders_video_pkg;

  localparam int H_W = 9;
  localparam int V_W = 9;

  localparam logic [H_W-1:0] H_TOTAL    = 9'd320;
  localparam logic [H_W-1:0] H_LAST     = 9'd319;
  localparam logic [H_W-1:0] H_ACTIVE   = 9'd256;
  localparam logic [H_W-1:0] HS_START   = 9'd272;
  localparam logic [H_W-1:0] HS_END     = 9'd304;
  localparam logic [H_W-1:0] FETCH_LEAD = 9'd4;

  // Vertical geometry defaults; the top level exposes these as parameters.
  localparam logic [V_W-1:0] V_TOTAL_DEF  = 9'd262;
  localparam logic [V_W-1:0] V_ACTIVE_DEF = 9'd224;
  localparam logic [V_W-1:0] VS_START_DEF = 9'd236;
  localparam logic [V_W-1:0] VS_END_DEF   = 9'd240;
  localparam logic [V_W-1:0] MID_LINE_DEF = 9'd96;

  localparam logic [12:0] FB_BASE  = 13'h0400;
  localparam logic [7:0]  RST1_VEC = 8'hCF;
  localparam logic [7:0]  RST2_VEC = 8'hD7;

  typedef struct packed {
    logic hblank;
    logic vblank;
    logic hsync;
    logic vsync;
  } raster_flags_t;

  typedef enum logic [1:0] {
    IRQ_NONE = 2'd0,
    IRQ_MID  = 2'd1,
    IRQ_END  = 2'd2
  } irq_event_e;

  // 32 bytes per line, so the line number lands directly above the byte column.
  function automatic logic [12:0] fb_addr(input logic [7:0] line,
                                          input logic [4:0] col_byte);
    return FB_BASE + {line, col_byte};
  endfunction

endpackage

// File: rtl/invaders_video_timing.sv
// Horizontal/vertical raster counters with registered blank and sync flags.
// Flags are decoded from the next counter values so they move with H/V.
module invaders_video_timing
  import invaders_video_pkg::*;
#(
  parameter logic [V_W-1:0] V_TOTAL  = V_TOTAL_DEF,
  parameter logic [V_W-1:0] V_ACTIVE = V_ACTIVE_DEF,
  parameter logic [V_W-1:0] VS_START = VS_START_DEF,
  parameter logic [V_W-1:0] VS_END   = VS_END_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           pix_ce,
  output logic [H_W-1:0] h,
  output logic [V_W-1:0] v,
  output logic [V_W-1:0] line_next,
  output logic           hblank,
  output logic           vblank,
  output logic           hsync,
  output logic           vsync
);

  logic [H_W-1:0] h_nxt;
  logic [V_W-1:0] v_nxt;
  raster_flags_t  flags_nxt;
  raster_flags_t  flags_q;

  always_comb begin
    line_next = (v == V_TOTAL - 9'd1) ? '0 : v + 9'd1;
    h_nxt     = h;
    v_nxt     = v;
    if (pix_ce) begin
      if (h == H_LAST) begin
        h_nxt = '0;
        v_nxt = line_next;
      end else begin
        h_nxt = h + 9'd1;
      end
    end
  end

  always_comb begin
    flags_nxt        = '0;
    flags_nxt.hblank = (h_nxt >= H_ACTIVE);
    flags_nxt.vblank = (v_nxt >= V_ACTIVE);
    flags_nxt.hsync  = (h_nxt >= HS_START) && (h_nxt < HS_END);
    flags_nxt.vsync  = (v_nxt >= VS_START) && (v_nxt < VS_END);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h       <= '0;
      v       <= '0;
      flags_q <= '0;
    end else begin
      h       <= h_nxt;
      v       <= v_nxt;
      flags_q <= flags_nxt;
    end
  end

  assign hblank = flags_q.hblank;
  assign vblank = flags_q.vblank;
  assign hsync  = flags_q.hsync;
  assign vsync  = flags_q.vsync;

endmodule

// File: rtl/invaders_video_fetch.sv
// Framebuffer fetch, LSB-first pixel serializer and per-frame RST 1 / RST 2
// interrupt requests on top of the raster timing generator.
module invaders_video_fetch
  import invaders_video_pkg::*;
#(
  parameter logic [V_W-1:0] V_TOTAL  = V_TOTAL_DEF,
  parameter logic [V_W-1:0] V_ACTIVE = V_ACTIVE_DEF,
  parameter logic [V_W-1:0] VS_START = VS_START_DEF,
  parameter logic [V_W-1:0] VS_END   = VS_END_DEF,
  parameter logic [V_W-1:0] MID_LINE = MID_LINE_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_ce,
  output logic [12:0] vid_addr,
  output logic        vid_rd,
  input  logic [7:0]  vid_data,
  output logic        pixel,
  output logic        hblank,
  output logic        vblank,
  output logic        hsync,
  output logic        vsync,
  output logic        irq_req,
  output logic [7:0]  irq_vec,
  input  logic        irq_ack
);

  logic [H_W-1:0] h;
  logic [V_W-1:0] v;
  logic [V_W-1:0] line_next;
  logic [H_W-1:0] tgt_col;
  logic [V_W-1:0] tgt_line;
  logic           fetch_slot;
  logic           fetch_ok;
  logic           rd_q;
  logic [7:0]     hold_q;
  logic [7:0]     shift_q;
  irq_event_e     irq_ev;

  invaders_video_timing #(
    .V_TOTAL  (V_TOTAL),
    .V_ACTIVE (V_ACTIVE),
    .VS_START (VS_START),
    .VS_END   (VS_END)
  ) u_timing (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_ce    (pix_ce),
    .h         (h),
    .v         (v),
    .line_next (line_next),
    .hblank    (hblank),
    .vblank    (vblank),
    .hsync     (hsync),
    .vsync     (vsync)
  );

  // Fetch runs four pixels ahead; the last slot of a line targets column 0
  // of the following line.
  always_comb begin
    tgt_col  = h + FETCH_LEAD;
    tgt_line = v;
    if (tgt_col >= H_TOTAL) begin
      tgt_col  = '0;
      tgt_line = line_next;
    end
  end

  assign fetch_slot = pix_ce && (h[2:0] == 3'd4);
  assign fetch_ok   = (tgt_line < V_ACTIVE) && (tgt_col < H_ACTIVE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid_rd   <= 1'b0;
      vid_addr <= FB_BASE;
      rd_q     <= 1'b0;
      hold_q   <= '0;
    end else begin
      vid_rd <= fetch_slot && fetch_ok;
      rd_q   <= vid_rd;
      if (fetch_slot && fetch_ok) begin
        vid_addr <= fb_addr(tgt_line[7:0], tgt_col[7:3]);
      end
      // RAM answers one clock after the address strobe.
      if (rd_q) begin
        hold_q <= vid_data;
      end else if (fetch_slot && !fetch_ok) begin
        hold_q <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
    end else if (pix_ce) begin
      if (h[2:0] == 3'd7) begin
        shift_q <= hold_q;
      end else begin
        shift_q <= {1'b0, shift_q[7:1]};
      end
    end
  end

  assign pixel = shift_q[0] && !hblank && !vblank;

  always_comb begin
    irq_ev = IRQ_NONE;
    if (pix_ce && (h == H_LAST)) begin
      if (line_next == V_ACTIVE) begin
        irq_ev = IRQ_END;
      end else if (line_next == MID_LINE) begin
        irq_ev = IRQ_MID;
      end
    end
  end

  // A new event outranks an acknowledge arriving in the same clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_req <= 1'b0;
      irq_vec <= 8'h00;
    end else begin
      case (irq_ev)
        IRQ_MID: begin
          irq_req <= 1'b1;
          irq_vec <= RST1_VEC;
        end
        IRQ_END: begin
          irq_req <= 1'b1;
          irq_vec <= RST2_VEC;
        end
        default: begin
          if (irq_ack) begin
            irq_req <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
